// File: rtl/multi_bank_reader.sv
// Reads the same word range from BANKS parallel BRAMs and streams each word
// set out as one AXI-Stream beat, throttling issue so the output FIFO never overflows.
module multi_bank_reader #(
  parameter int BANKS      = 4,
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 256,
  parameter int ADDR       = $clog2(DEPTH),
  parameter int LEN_W      = ADDR + 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [ADDR-1:0]          base_addr,
  input  logic [LEN_W-1:0]         count,
  output logic                     busy,
  output logic                     done,
  output logic [BANKS-1:0]         enb,
  output logic [BANKS*ADDR-1:0]    addrb,
  input  logic [BANKS*WIDTH-1:0]   doutb,
  input  logic [BANKS-1:0]         validb,
  output logic [BANKS*WIDTH-1:0]   m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                 state_q;
  logic                   busy_q, done_q, enb_q;
  logic [ADDR-1:0]        addrb_q, next_addr_q;
  logic [LEN_W-1:0]       remain_q, len_q, beat_q;
  logic [CW-1:0]          outstanding_q, outstanding_d;
  logic [CW-1:0]          fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]          wptr_q, rptr_q;
  logic [BANKS*WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                   issue_d, capture, pop;
  logic [CW:0]            inflight;

  assign busy     = busy_q;
  assign done     = done_q;
  assign enb      = {BANKS{enb_q}};
  assign addrb    = {BANKS{addrb_q}};
  assign m_tvalid = (fifo_cnt_q != '0);
  assign m_tdata  = mem_q[rptr_q];
  assign m_tlast  = m_tvalid && (beat_q == len_q - LEN_W'(1));
  assign pop      = m_tvalid && m_tready;

  // Requiring outstanding reads lets stale responses after a reset fall on the floor.
  assign capture  = (&validb) && (state_q != IDLE) && (outstanding_q != '0);

  // The read on the wire this cycle (enb_q) already holds a FIFO slot.
  assign inflight = (CW+1)'(outstanding_q) + (CW+1)'(fifo_cnt_q) + (CW+1)'(enb_q);
  assign issue_d  = (state_q == ISSUE) && (remain_q != '0) &&
                    (inflight < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    outstanding_d = outstanding_q;
    if (enb_q && !capture)
      outstanding_d = outstanding_q + CW'(1);
    else if (!enb_q && capture)
      outstanding_d = outstanding_q - CW'(1);

    fifo_cnt_d = fifo_cnt_q;
    if (capture && !pop)
      fifo_cnt_d = fifo_cnt_q + CW'(1);
    else if (!capture && pop)
      fifo_cnt_d = fifo_cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      enb_q         <= 1'b0;
      addrb_q       <= '0;
      next_addr_q   <= '0;
      remain_q      <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      outstanding_q <= '0;
      fifo_cnt_q    <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      done_q        <= 1'b0;
      enb_q         <= issue_d;
      outstanding_q <= outstanding_d;
      fifo_cnt_q    <= fifo_cnt_d;
      if (capture) wptr_q <= wptr_q + PW'(1);
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
        beat_q <= beat_q + LEN_W'(1);
      end
      if (issue_d) begin
        addrb_q     <= next_addr_q;
        next_addr_q <= next_addr_q + ADDR'(1);
        remain_q    <= remain_q - LEN_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              state_q     <= ISSUE;
              busy_q      <= 1'b1;
              next_addr_q <= base_addr;
              remain_q    <= count;
              len_q       <= count;
              beat_q      <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (remain_q == '0) state_q <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_tlast) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (capture) mem_q[wptr_q] <= doutb;
  end

endmodule

// File: tb/tb_multi_bank_reader.sv
// Self-checking bench for multi_bank_reader: a 2-cycle BRAM model where bank i
// at address a returns {i,a}, table-driven streams plus reset/chain/zero cases.
module tb_multi_bank_reader;

  localparam int BANKS = 4;
  localparam int WIDTH = 16;
  localparam int ADDR  = 8;
  localparam int LEN_W = 9;
  localparam int FD    = 4;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   start = 1'b0;
  logic [ADDR-1:0]        base_addr = '0;
  logic [LEN_W-1:0]       count = '0;
  logic                   busy, done;
  logic [BANKS-1:0]       enb;
  logic [BANKS*ADDR-1:0]  addrb;
  logic [BANKS*WIDTH-1:0] doutb;
  logic [BANKS-1:0]       validb;
  logic [BANKS*WIDTH-1:0] m_tdata;
  logic                   m_tvalid, m_tlast;
  logic                   m_tready = 1'b0;
  logic                   spurious = 1'b0;

  int checks = 0;
  int errors = 0;

  multi_bank_reader #(
    .BANKS(BANKS), .WIDTH(WIDTH), .DEPTH(256), .ADDR(ADDR), .LEN_W(LEN_W), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .enb(enb), .addrb(addrb), .doutb(doutb), .validb(validb),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  // BRAM model with two-cycle latency; it keeps running through reset.
  logic [BANKS-1:0]      p1v = '0, p2v = '0;
  logic [BANKS*ADDR-1:0] p1a = '0, p2a = '0;

  always @(posedge clk) begin
    p1v <= enb;
    p1a <= addrb;
    p2v <= p1v;
    p2a <= p1a;
  end

  always_comb begin
    doutb  = '0;
    validb = p2v | {BANKS{spurious}};
    for (int i = 0; i < BANKS; i++)
      doutb[i*WIDTH +: WIDTH] = {8'(i), p2a[i*ADDR +: ADDR]};
  end

  typedef struct {
    logic [7:0] base;
    int         cnt;
    int         stall;
    logic [7:0] expFirst;
    logic [7:0] expLast;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] expBeat(input logic [7:0] a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < BANKS; i++) r[i*WIDTH +: WIDTH] = {8'(i), a};
    return r;
  endfunction

  task automatic applyStimulus(input logic [7:0] b, input int c);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    count     = LEN_W'(c);
  endtask

  // Collects one command's stream; optionally fires a stray start while busy
  // and chains the next command in the done cycle.
  task automatic collectStream(input logic [7:0] b, input int c, input int stall, input int bogusAt,
                               input bit chain, input logic [7:0] nb, input int nc,
                               output logic [7:0] firstA, output logic [7:0] lastA);
    int          issued = 0;
    int          beats = 0;
    bit          pend = 0;
    bit          fin = 0;
    bit          haveHeld = 0;
    logic [7:0]  lastIss = '0;
    logic [63:0] held = '0;
    firstA = '0;
    lastA  = '0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == bogusAt) begin
        start     = 1'b1;
        base_addr = 8'h77;
        count     = 9'd5;
      end
      if (cyc == 0) checkOutput("busy_rise", busy, 1);
      if (enb != '0) begin
        checkOutput("enb_all", enb, 4'hF);
        checkOutput("addrb_seq", addrb, {4{b + 8'(issued)}});
        lastIss = b + 8'(issued);
        issued++;
        checkOutput("inflight_bound", issued - beats <= FD, 1);
      end else if (issued > 0) begin
        checkOutput("addrb_hold", addrb, {4{lastIss}});
      end
      m_tready = (cyc >= stall);
      if (pend) begin
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_fall", busy, 0);
        fin = 1;
        if (chain) begin
          start     = 1'b1;
          base_addr = nb;
          count     = LEN_W'(nc);
        end
      end else begin
        if (!m_tready && m_tvalid) begin
          if (haveHeld) checkOutput("stall_hold", m_tdata, held);
          held     = m_tdata;
          haveHeld = 1;
        end
        if (m_tvalid && m_tready) begin
          checkOutput("beat_data", m_tdata, expBeat(b + 8'(beats)));
          checkOutput("beat_last", m_tlast, beats == c - 1);
          if (beats == 0) firstA = m_tdata[7:0];
          lastA = m_tdata[7:0];
          beats++;
          if (m_tlast) pend = 1;
        end
      end
      if (stall > 0 && cyc == stall) checkOutput("stall_reads", issued <= FD, 1);
    end
    checkOutput("beat_count", beats, c);
    checkOutput("completed", fin, 1);
    if (!chain) begin
      @(negedge clk);
      checkOutput("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       vecs[6];
    logic [7:0] f, l;
    int         beats;
    bit         reached;

    vecs[0] = '{base: 8'h10, cnt: 3,  stall: 0,  expFirst: 8'h10, expLast: 8'h12};
    vecs[1] = '{base: 8'hFE, cnt: 4,  stall: 0,  expFirst: 8'hFE, expLast: 8'h01};
    vecs[2] = '{base: 8'h00, cnt: 8,  stall: 20, expFirst: 8'h00, expLast: 8'h07};
    vecs[3] = '{base: 8'h80, cnt: 1,  stall: 0,  expFirst: 8'h80, expLast: 8'h80};
    vecs[4] = '{base: 8'hF0, cnt: 16, stall: 3,  expFirst: 8'hF0, expLast: 8'hFF};
    vecs[5] = '{base: 8'h33, cnt: 5,  stall: 7,  expFirst: 8'h33, expLast: 8'h37};

    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_enb", enb, 0);
    checkOutput("rst_tvalid", m_tvalid, 0);
    checkOutput("rst_tlast", m_tlast, 0);
    checkOutput("rst_addrb", addrb, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].base, vecs[i].cnt);
      collectStream(vecs[i].base, vecs[i].cnt, vecs[i].stall, -1, 1'b0, 8'h00, 0, f, l);
      checkOutput("first_addr", f, vecs[i].expFirst);
      checkOutput("last_addr", l, vecs[i].expLast);
    end

    // Zero-length command: done next cycle, nothing issued or streamed.
    applyStimulus(8'h55, 0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("zero_enb", enb, 0);
      checkOutput("zero_tvalid", m_tvalid, 0);
      checkOutput("zero_done_off", done, 0);
    end

    // Read-valid while idle must not enter the FIFO.
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    spurious = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("idle_valid_drop", m_tvalid, 0);
    end

    // Reset asserted while beat 2 of 6 is presented.
    applyStimulus(8'h40, 6);
    beats   = 0;
    reached = 0;
    m_tready = 1'b1;
    for (int cyc = 0; cyc < 100 && !reached; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_tvalid) begin
        if (beats == 2) begin
          reached = 1;
          rstn = 1'b0;
          #1;
          checkOutput("abort_busy", busy, 0);
          checkOutput("abort_done", done, 0);
          checkOutput("abort_enb", enb, 0);
          checkOutput("abort_tvalid", m_tvalid, 0);
          checkOutput("abort_tlast", m_tlast, 0);
          checkOutput("abort_addrb", addrb, 0);
        end else begin
          beats++;
        end
      end
    end
    checkOutput("abort_reached", reached, 1);
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("post_abort_done", done, 0);
      checkOutput("post_abort_tvalid", m_tvalid, 0);
    end
    applyStimulus(8'h60, 4);
    collectStream(8'h60, 4, 0, -1, 1'b0, 8'h00, 0, f, l);
    checkOutput("fresh_last", l, 8'h63);

    // Stray start while busy, then the next command launched in the done cycle.
    applyStimulus(8'h20, 3);
    collectStream(8'h20, 3, 2, 1, 1'b1, 8'h50, 2, f, l);
    checkOutput("chain_a_last", l, 8'h22);
    collectStream(8'h50, 2, 0, -1, 1'b0, 8'h00, 0, f, l);
    checkOutput("chain_b_first", f, 8'h50);
    checkOutput("chain_b_last", l, 8'h51);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_bank_reader.md
MULTI_BANK_READER -- requirements
Module: multi_bank_reader

Interface
REQ-001 SHALL have parameter BANKS, default 4, number of parallel BRAM banks.
REQ-002 SHALL have parameter WIDTH, default 16, data width per bank.
REQ-003 SHALL have parameter DEPTH, default 256, words per bank, power of two.
REQ-004 SHALL have parameter ADDR, default LOG2(DEPTH), address width per bank.
REQ-005 SHALL have parameter LEN_W, default ADDR+1, width of the transfer count.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, power of two, at least 2.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, command strobe.
REQ-010 SHALL have port base_addr, input, ADDR, first word address, common to all banks.
REQ-011 SHALL have port count, input, LEN_W, number of words to read.
REQ-012 SHALL have port busy, output, 1, high while a command is active.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port enb, output, BANKS, per-bank read enable.
REQ-015 SHALL have port addrb, output, BANKS*ADDR, per-bank read address, bank i at bits [(i+1)*ADDR-1 : i*ADDR].
REQ-016 SHALL have port doutb, input, BANKS*WIDTH, per-bank read data, same packing.
REQ-017 SHALL have port validb, input, BANKS, per-bank read-data-valid.
REQ-018 SHALL have port m_tdata, output, BANKS*WIDTH, stream data, bank i in slice i.
REQ-019 SHALL have ports m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1), AXI-Stream handshake and last-beat marker.

Function
REQ-020 SHALL implement states IDLE, ISSUE and DRAIN.
- IDLE -> ISSUE on start with count>0.
- ISSUE -> DRAIN after the last read is issued.
- DRAIN -> IDLE on the m_tlast handshake.
REQ-021 SHALL accept start only in IDLE; start while busy is ignored.
REQ-022 SHALL latch base_addr and count on the start cycle.
REQ-023 SHALL raise busy in the cycle after start is accepted and hold it until IDLE is re-entered.
REQ-024 SHALL treat start with count=0 as follows: pulse done in the next cycle, issue no reads, emit no beats, keep busy low.
REQ-025 SHALL issue read k (k=0..count-1) by driving enb all-ones and every addrb slice to (base_addr+k) mod 2^ADDR in one cycle; wrap-around past DEPTH-1 to 0 is legal.
REQ-026 SHALL issue at most one read per cycle, and only while outstanding reads plus stored FIFO entries is less than FIFO_DEPTH, so data is never dropped under backpressure.
REQ-027 SHALL hold enb at zero when not issuing, and addrb stable at the last value.
REQ-028 SHALL capture a response only when all validb bits are high in the same cycle, writing doutb into the FIFO; BRAM read latency is fixed, at least 1, and identical across banks.
REQ-029 SHALL count an outstanding read from the cycle after issue until its response is captured, and support a read-to-response latency of up to FIFO_DEPTH cycles.
REQ-030 SHALL drive m_tvalid whenever the FIFO is non-empty, with m_tdata equal to the FIFO head, held stable until m_tready.
REQ-031 SHALL assert m_tlast only on beat count-1.
REQ-032 SHALL pulse done for exactly one cycle, in the cycle after the m_tlast handshake.
REQ-033 SHALL support a simultaneous FIFO push and pop in one cycle with no change in occupancy.
REQ-034 SHALL discard validb received in IDLE.
REQ-035 SHALL allow back-to-back commands: start may be accepted in the cycle done is high.
REQ-036 SHALL preserve word order exactly: beat k carries word base_addr+k from every bank.

Reset
REQ-037 SHALL, while rstn is low, force the following immediately and asynchronously:
- state IDLE, FIFO empty, all counters zero;
- busy, done, enb, m_tvalid and m_tlast low;
- addrb zero.
REQ-038 SHALL abort any active command on reset mid-transfer with no done pulse, and drop late responses from reads issued before reset.

Verification
REQ-039 SHALL pass this scenario: banks preloaded so that bank i at address a holds {i,a}; start base=0x10, count=3, m_tready=1 -> 3 beats with data at addresses 0x10, 0x11, 0x12, tlast on the third, then done one cycle later.
REQ-040 SHALL pass this scenario: base=0xFE, count=4 -> addrb sequence 0xFE, 0xFF, 0x00, 0x01, with beats in that order.
REQ-041 SHALL pass this scenario: count=8, m_tready held low for 20 cycles -> at most FIFO_DEPTH reads issued and m_tdata stable; on release all 8 beats arrive with no loss or duplication.
REQ-042 SHALL pass this scenario: start with count=0 -> done high in the next cycle, enb never asserted, no beats.
REQ-043 SHALL pass this scenario: rstn pulsed low during beat 2 of 6 -> all outputs at reset values in the same cycle; no done; a fresh command then completes correctly.
REQ-044 SHALL pass this scenario: start re-asserted during busy, and back-to-back commands issued in the done cycle -> the first is ignored and the second is accepted, with a correct stream.
